byte_counter: RTL and testbench

BYTE_COUNTER -- requirements
Module: byte_counter

---
 rtl/byte_counter_pkg.sv | 7 +
 rtl/byte_counter.sv | 37 +++
 tb/tb_byte_counter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/byte_counter_pkg.sv
// Shared sizing constants for the byte counter and the I2C master that consumes it.
package byte_counter_pkg;

  localparam int DEF_LEN_W  = 6;
  localparam int MAX_PACKET = 2 ** DEF_LEN_W;

endpackage : byte_counter_pkg

// File: rtl/byte_counter.sv
// Down-counter of bytes remaining in a packet. It is loaded from packet_length,
// saturates at zero, and flags zero combinationally from the count register.
module byte_counter
  import byte_counter_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = LEN_W + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             decrement,
  input  logic             load_buffer,
  input  logic [LEN_W-1:0] packet_length,
  output logic             zero
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] load_value;

  // A length of 0 encodes a full packet of 2**LEN_W bytes.
  assign load_value = (packet_length == '0) ? (CNT_W'(1) << LEN_W)
                                            : CNT_W'(packet_length);

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      count <= '0;
    end else if (load_buffer) begin
      count <= load_value;
    end else if (decrement && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule : byte_counter

// File: tb/tb_byte_counter.sv
// Directed bench for byte_counter: a vector table, then multi-cycle sequences
// covering the full length sweep, the encoded maximum, saturation, priority and async reset.
module tb_byte_counter;

  localparam int LEN_W = 6;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             decrement;
  logic             load_buffer;
  logic [LEN_W-1:0] packet_length;
  logic             zero;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic             load;
    logic             dec;
    logic [LEN_W-1:0] len;
    logic             exp_zero;
  } vec_t;

  byte_counter #(.LEN_W(LEN_W)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .decrement     (decrement),
    .load_buffer   (load_buffer),
    .packet_length (packet_length),
    .zero          (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: zero=%b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive inputs mid-cycle, take one rising edge, and settle 1 time unit after it.
  task automatic step(input logic load, input logic dec, input logic [LEN_W-1:0] len);
    load_buffer   = load;
    decrement     = dec;
    packet_length = len;
    @(posedge clk);
    #1;
    load_buffer   = 1'b0;
    decrement     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 6'd5, 1'b1};  // idle after reset, length ignored
    vecs[1]  = '{1'b1, 1'b0, 6'd2, 1'b0};  // load 2
    vecs[2]  = '{1'b0, 1'b1, 6'd7, 1'b0};  // -> 1
    vecs[3]  = '{1'b0, 1'b0, 6'd0, 1'b0};  // hold 1
    vecs[4]  = '{1'b0, 1'b1, 6'd0, 1'b1};  // -> 0
    vecs[5]  = '{1'b0, 1'b1, 6'd0, 1'b1};  // saturate
    vecs[6]  = '{1'b1, 1'b1, 6'd1, 1'b0};  // load wins -> 1
    vecs[7]  = '{1'b0, 1'b1, 6'd0, 1'b1};  // -> 0
    vecs[8]  = '{1'b1, 1'b0, 6'd0, 1'b0};  // load 64
    vecs[9]  = '{1'b1, 1'b0, 6'd1, 1'b0};  // reload overwrites -> 1
    vecs[10] = '{1'b0, 1'b1, 6'd0, 1'b1};  // -> 0

    decrement     = 1'b0;
    load_buffer   = 1'b0;
    packet_length = '0;
    n_rst         = 1'b0;
    #2 n_rst = 1'b1;
    #1 check("reset_async", zero, 1'b1);
    @(posedge clk);
    #1 check("reset_held", zero, 1'b1);
    n_rst = 1'b0;
    idle(2);
    check("reset_release_idle", zero, 1'b1);

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].load, vecs[i].dec, vecs[i].len);
      check($sformatf("vec%0d", i), zero, vecs[i].exp_zero);
    end

    // Full sweep with two idle cycles between decrement pulses.
    for (int l = 1; l < 64; l++) begin
      step(1'b1, 1'b0, LEN_W'(l));
      for (int p = 1; p <= l; p++) begin
        check($sformatf("sweep%0d_pre%0d", l, p), zero, 1'b0);
        step(1'b0, 1'b1, '0);
        idle(2);
      end
      check($sformatf("sweep%0d_end", l), zero, 1'b1);
    end

    // Encoded maximum: length 0 means 64 bytes.
    step(1'b1, 1'b0, '0);
    for (int p = 0; p < 63; p++) step(1'b0, 1'b1, '0);
    check("max_after63", zero, 1'b0);
    step(1'b0, 1'b1, '0);
    check("max_after64", zero, 1'b1);

    // Saturation at zero, then a normal packet.
    for (int p = 0; p < 3; p++) begin
      step(1'b0, 1'b1, '0);
      check($sformatf("sat_pulse%0d", p), zero, 1'b1);
    end
    step(1'b1, 1'b0, 6'd5);
    for (int p = 0; p < 4; p++) step(1'b0, 1'b1, '0);
    check("sat_load5_after4", zero, 1'b0);
    step(1'b0, 1'b1, '0);
    check("sat_load5_after5", zero, 1'b1);

    // Priority: load and decrement together while count is 3.
    step(1'b1, 1'b0, 6'd3);
    step(1'b1, 1'b1, 6'd10);
    for (int p = 0; p < 9; p++) step(1'b0, 1'b1, '0);
    check("prio_after9", zero, 1'b0);
    step(1'b0, 1'b1, '0);
    check("prio_after10", zero, 1'b1);

    // Asynchronous reset mid-count, between clock edges.
    step(1'b1, 1'b0, 6'd20);
    for (int p = 0; p < 5; p++) step(1'b0, 1'b1, '0);
    check("areset_pre", zero, 1'b0);
    #2 n_rst = 1'b1;
    #1 check("areset_immediate", zero, 1'b1);
    #1 n_rst = 1'b0;
    @(posedge clk);
    #1;
    idle(3);
    check("areset_wait_load", zero, 1'b1);
    step(1'b1, 1'b0, 6'd1);
    check("areset_new_load", zero, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_byte_counter
